// File: rtl/lapido_pipe_pkg.sv
// Shared constants and state encoding for the Lapido MEM/WB stage.
package lapido_pipe_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 4;

  // The encoding is {skid valid, head valid}, so the state is read straight off the valid bits
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } wb_state_t;

  function automatic logic [1:0] occ_of(input logic h_vld, input logic s_vld);
    return {1'b0, h_vld} + {1'b0, s_vld};
  endfunction
endpackage

// File: rtl/mem_wb_entry_reg.sv
// One valid-tagged MEM/WB entry. It updates on the falling clock edge; clear wins over load.
module mem_wb_entry_reg
  import lapido_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_mem,
  input  logic [DATA_W-1:0] d_alu,
  input  logic              d_m2r,
  input  logic              d_rw,
  input  logic [REG_W-1:0]  d_reg,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_mem,
  output logic [DATA_W-1:0] q_alu,
  output logic              q_m2r,
  output logic              q_rw,
  output logic [REG_W-1:0]  q_reg
);
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_mem   <= '0;
      q_alu   <= '0;
      q_m2r   <= 1'b0;
      q_rw    <= 1'b0;
      q_reg   <= '0;
    end else if (clear) begin
      q_valid <= 1'b0;  // payload is left stale, because every consumer gates it with valid
    end else if (load) begin
      q_valid <= 1'b1;
      q_mem   <= d_mem;
      q_alu   <= d_alu;
      q_m2r   <= d_m2r;
      q_rw    <= d_rw;
      q_reg   <= d_reg;
    end
  end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: a head register plus a skid register with a valid/ready handshake.
// It also provides flush, write-back data selection and a forwarding tap.
module mem_wb_stage
  import lapido_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] DataOutDataMemory_in,
  input  logic [DATA_W-1:0] ALUResult_in,
  input  logic              memToReg_in,
  input  logic              regWrite_in,
  input  logic [REG_W-1:0]  registerFileWrite_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] DataOutDataMemory,
  output logic [DATA_W-1:0] ALUResult,
  output logic              memToReg,
  output logic              regWrite,
  output logic [REG_W-1:0]  registerFileWrite,
  output logic [DATA_W-1:0] writeBackData,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic [1:0]        occupancy
);
  logic              h_vld, s_vld, h_rw;
  logic [DATA_W-1:0] s_mem, s_alu;
  logic              s_m2r, s_rw;
  logic [REG_W-1:0]  s_reg;
  logic              h_load, h_clr, h_from_s, s_load, s_clr;
  logic              accept, pop;
  wb_state_t         state;

  assign state    = wb_state_t'({s_vld, h_vld});
  assign in_ready = ~s_vld;
  assign accept   = in_valid & in_ready;
  assign pop      = h_vld & out_ready;

  always_comb begin
    h_load   = 1'b0;
    h_clr    = 1'b0;
    h_from_s = 1'b0;
    s_load   = 1'b0;
    s_clr    = 1'b0;
    if (flush) begin
      h_clr = 1'b1;
      s_clr = 1'b1;
    end else begin
      case (state)
        EMPTY: h_load = accept;
        ONE: begin
          if (pop && accept) h_load = 1'b1;
          else if (pop)      h_clr  = 1'b1;
          else if (accept)   s_load = 1'b1;
        end
        FULL: begin
          if (pop) begin
            h_load   = 1'b1;
            h_from_s = 1'b1;
            s_clr    = 1'b1;
          end
        end
        default: begin
          // This state is unreachable. If it occurs, the skid entry is promoted so that it is not lost.
          h_load   = 1'b1;
          h_from_s = 1'b1;
          s_clr    = 1'b1;
        end
      endcase
    end
  end

  mem_wb_entry_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) u_head (
    .clock   (clock),
    .reset   (reset),
    .load    (h_load),
    .clear   (h_clr),
    .d_mem   (h_from_s ? s_mem : DataOutDataMemory_in),
    .d_alu   (h_from_s ? s_alu : ALUResult_in),
    .d_m2r   (h_from_s ? s_m2r : memToReg_in),
    .d_rw    (h_from_s ? s_rw  : regWrite_in),
    .d_reg   (h_from_s ? s_reg : registerFileWrite_in),
    .q_valid (h_vld),
    .q_mem   (DataOutDataMemory),
    .q_alu   (ALUResult),
    .q_m2r   (memToReg),
    .q_rw    (h_rw),
    .q_reg   (registerFileWrite)
  );

  mem_wb_entry_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) u_skid (
    .clock   (clock),
    .reset   (reset),
    .load    (s_load),
    .clear   (s_clr),
    .d_mem   (DataOutDataMemory_in),
    .d_alu   (ALUResult_in),
    .d_m2r   (memToReg_in),
    .d_rw    (regWrite_in),
    .d_reg   (registerFileWrite_in),
    .q_valid (s_vld),
    .q_mem   (s_mem),
    .q_alu   (s_alu),
    .q_m2r   (s_m2r),
    .q_rw    (s_rw),
    .q_reg   (s_reg)
  );

  assign out_valid     = h_vld;
  assign regWrite      = h_rw & h_vld;
  assign writeBackData = memToReg ? DataOutDataMemory : ALUResult;
  assign fwd_valid     = regWrite & (|registerFileWrite);
  assign fwd_reg       = registerFileWrite;
  assign fwd_data      = writeBackData;
  assign occupancy     = occ_of(h_vld, s_vld);
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Parametrised MEM/WB pipeline stage for the Lapido processor. It supersedes the fixed 32-bit, always-load MEM/WB register.
- Adds a valid/ready handshake with a 2-entry skid buffer, so the stage absorbs one back-pressure cycle without dropping data.
- Also adds a synchronous flush, write-back data selection (memory vs ALU), and a forwarding tap for the hazard unit.

Parameters:
- DATA_W, 32, width of memory read data, ALU result and write-back data
- REG_W, 4, width of destination register index

Ports:
- clock  in  1  stage clock; all state updates on falling edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  MEM stage presents an entry
- in_ready  out  1  stage can accept an entry this cycle
- DataOutDataMemory_in  in  DATA_W  data memory read data
- ALUResult_in  in  DATA_W  ALU result
- memToReg_in  in  1  1 = write back memory data, 0 = ALU result
- regWrite_in  in  1  entry writes the register file
- registerFileWrite_in  in  REG_W  destination register index
- out_valid  out  1  head entry valid
- out_ready  in  1  WB/register file consumes head entry
- DataOutDataMemory  out  DATA_W  head memory data
- ALUResult  out  DATA_W  head ALU result
- memToReg  out  1  head select bit
- regWrite  out  1  head write enable, gated by out_valid
- registerFileWrite  out  REG_W  head destination index
- writeBackData  out  DATA_W  memToReg ? DataOutDataMemory : ALUResult (combinational from head)
- fwd_valid  out  1  out_valid & regWrite & (registerFileWrite != 0)
- fwd_reg  out  REG_W  equals registerFileWrite
- fwd_data  out  DATA_W  equals writeBackData
- occupancy  out  2  entries held, 0..2

Behaviour:
- Storage: head register H and skid register S, each with a valid bit. All outputs are driven from H.
- Reset (async, dominates everything): H.valid = S.valid = 0. All data/index/select fields are 0. in_ready = 1, out_valid = 0, regWrite = 0, fwd_valid = 0, occupancy = 0.
- in_ready = !S.valid; it is registered state, not combinational from out_ready. Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Latency: an accepted entry into an empty stage appears at the outputs after the same falling edge (1-cycle stage latency, matching the old register).
- Transitions each falling edge, with (H.valid, S.valid) as state:
  - EMPTY (0,0): accept -> H <= in, go ONE.
  - ONE (1,0), pop and accept: H <= in, stay ONE.
  - ONE, pop only: go EMPTY.
  - ONE, accept only: S <= in, go FULL.
  - ONE, neither: hold.
  - FULL (1,1): accept is impossible (in_ready = 0). Pop: H <= S, S.valid <= 0, go ONE. No pop: hold.
- Order is strictly FIFO; the skid entry never overtakes the head.
- Flush (when not in reset): on the falling edge, H.valid <= 0 and S.valid <= 0. An entry presented that same cycle is discarded even if in_ready = 1. Data fields may hold stale values; regWrite and fwd_valid are 0 because they are gated by valid. in_ready = 1 the next cycle.
- An invalid head never writes: regWrite = H.regWrite & H.valid.
- Register index 0 is never forwarded (hard-wired zero register). It may still be written; the register file ignores that write.
- occupancy = H.valid + S.valid.
- Reset asserted mid-FULL: all entries are lost immediately; there is no partial drain.

Decomposition:
- Package lapido_pipe_pkg holds the default DATA_W/REG_W constants and a state encoding: EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11.
- One sub-module, mem_wb_entry_reg: a single valid-tagged entry register with load, clear and async reset. Instantiate it twice (H, S); the stage adds the control FSM and output muxing.

Test Plan:
- Reset mid-traffic: fill to FULL, assert reset between edges -> outputs zero immediately, in_ready = 1, occupancy = 0.
- Pass-through: out_ready = 1; feed ALU = 0x0000_0010, memToReg = 0, reg = 3, regWrite = 1 -> next edge writeBackData = 0x10, fwd_valid = 1, fwd_reg = 3.
- Back-pressure: out_ready = 0; feed A (mem = 0xDEAD_BEEF, memToReg = 1) then B (ALU = 0x5) -> occupancy = 2, in_ready = 0, head = 0xDEADBEEF. Raise out_ready -> pops A, then B, in order; in_ready returns to 1 after the first pop.
- Flush in FULL with in_valid = 1 -> next edge out_valid = 0, occupancy = 0, regWrite = 0; the presented entry never appears.
- Zero register: regWrite = 1, reg = 0 -> regWrite = 1, fwd_valid = 0.
- DATA_W = 16, REG_W = 5: rerun back-pressure with reg = 31, data 0xFFFF -> widths preserved, no truncation.
